// File: rtl/pipelined_binary_to_thermometer.sv
// Multi-lane binary-to-thermometer converter with unsigned/signed clamping,
// two register stages under a single global stall, and a saturation event counter.

module pbt_lane #(
    parameter int INPUT_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           adv,
    input  logic                           mode,
    input  logic [INPUT_WIDTH:0]           lane_in,
    output logic [(2**INPUT_WIDTH)-2:0]    therm,
    output logic                           sat
);
    localparam int THERM_W = 2**INPUT_WIDTH - 1;

    typedef struct packed {
        logic [INPUT_WIDTH-1:0] val;
        logic                   sat;
    } s1_t;

    typedef struct packed {
        logic [THERM_W-1:0] therm;
        logic               sat;
    } s2_t;

    s1_t                clamp_d;
    s1_t                s1_q;
    s2_t                s2_q;
    logic [THERM_W-1:0] therm_d;

    // A set top bit means out of range in both modes: unsigned >= 2**W clamps
    // to all ones (== THERM_W), signed negative clamps to zero.
    always_comb begin
        clamp_d.val = lane_in[INPUT_WIDTH-1:0];
        clamp_d.sat = 1'b0;
        if (lane_in[INPUT_WIDTH]) begin
            clamp_d.sat = 1'b1;
            clamp_d.val = mode ? '0 : '1;
        end
    end

    for (genvar k = 0; k < THERM_W; k++) begin : g_bit
        assign therm_d[k] = (INPUT_WIDTH'(k) < s1_q.val);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (adv) begin
            s1_q <= clamp_d;
            s2_q <= '{therm: therm_d, sat: s1_q.sat};
        end
    end

    assign therm = s2_q.therm;
    assign sat   = s2_q.sat;
endmodule

module pipelined_binary_to_thermometer #(
    parameter int INPUT_WIDTH = 3,
    parameter int NUM_LANES   = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         mode,
    input  logic                                         sat_clr,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [NUM_LANES*(INPUT_WIDTH+1)-1:0]         in_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [NUM_LANES*((2**INPUT_WIDTH)-1)-1:0]    out_therm,
    output logic [NUM_LANES-1:0]                         out_sat,
    output logic [CNT_WIDTH-1:0]                         sat_count
);
    localparam int THERM_W = 2**INPUT_WIDTH - 1;
    localparam int STAGES  = 2;

    logic                                 adv;
    logic [STAGES:1]                      vld_pipe;
    logic [NUM_LANES-1:0][INPUT_WIDTH:0]  lane_in;
    logic [NUM_LANES-1:0][THERM_W-1:0]    lane_therm;

    assign lane_in   = in_data;
    assign out_therm = lane_therm;
    assign out_valid = vld_pipe[STAGES];

    // Whole pipe moves together: a held output stalls every stage behind it.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (adv)
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pbt_lane #(.INPUT_WIDTH(INPUT_WIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv),
            .mode    (mode),
            .lane_in (lane_in[i]),
            .therm   (lane_therm[i]),
            .sat     (out_sat[i])
        );
    end

    // Clear beats a concurrent increment; the count sticks at all ones.
    always_ff @(posedge clk) begin
        if (rst || sat_clr)
            sat_count <= '0;
        else if (out_valid && out_ready && (|out_sat) && (sat_count != '1))
            sat_count <= sat_count + 1'b1;
    end
endmodule

// File: tb/tb_pipelined_binary_to_thermometer.sv
// Randomized bench for pipelined_binary_to_thermometer against an arithmetic reference model.

module tb_pipelined_binary_to_thermometer;
    localparam int IW = 3;
    localparam int NL = 2;
    localparam int CW = 2;
    localparam int TW = 7;
    localparam int DW = NL*(IW+1);
    localparam int OW = NL*TW;

    logic          clk = 1'b0;
    logic          rst, mode, sat_clr, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [OW-1:0] out_therm;
    logic [NL-1:0] out_sat;
    logic [CW-1:0] sat_count;

    always #5 clk = ~clk;

    pipelined_binary_to_thermometer #(.INPUT_WIDTH(IW), .NUM_LANES(NL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sat_clr(sat_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_therm(out_therm), .out_sat(out_sat), .sat_count(sat_count)
    );

    typedef struct {
        logic [OW-1:0] therm;
        logic [NL-1:0] sat;
        int            cyc;
    } beat_t;

    beat_t         q[$];
    beat_t         cur_exp;
    bit            have_exp, acc, xfer;
    logic [OW-1:0] obs_therm;
    logic [NL-1:0] obs_sat;
    logic          obs_ready, obs_valid;
    int            cyc, xfer_cyc, sat_model;
    int            tests_run, tests_failed;

    // Reference: interpret the lane as an integer, clamp to 0..TW, then fill v ones.
    function automatic beat_t model(input logic [DW-1:0] d, input logic m);
        beat_t      b;
        logic [IW:0] raw;
        int         v, c;
        b.therm = '0;
        b.sat   = '0;
        b.cyc   = 0;
        for (int i = 0; i < NL; i++) begin
            raw = d[i*(IW+1) +: IW+1];
            v = m ? int'($signed(raw)) : int'(raw);
            c = (v < 0) ? 0 : (v > TW) ? TW : v;
            b.sat[i] = (v < 0) || (v > TW);
            b.therm[i*TW +: TW] = TW'((1 << c) - 1);
        end
        return b;
    endfunction

    // Drive one cycle, record handshakes, advance the models, return at the next negedge.
    task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic m, input logic ordy, input logic clr);
        beat_t b;
        rst = r; in_valid = v; in_data = d; mode = m; out_ready = ordy; sat_clr = clr;
        #1;
        obs_ready = in_ready; obs_valid = out_valid; obs_therm = out_therm; obs_sat = out_sat;
        acc  = !r && v && (in_ready === 1'b1);
        xfer = !r && ordy && (out_valid === 1'b1);
        xfer_cyc = cyc;
        have_exp = 1'b0;
        if (xfer && q.size() > 0) begin
            cur_exp  = q.pop_front();
            have_exp = 1'b1;
        end
        if (acc) begin
            b = model(d, m);
            b.cyc = cyc;
            q.push_back(b);
        end
        if (r) begin
            q.delete();
            sat_model = 0;
        end else if (clr)
            sat_model = 0;
        else if (xfer && have_exp && (|cur_exp.sat) && sat_model < 3)
            sat_model++;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, DW'($urandom), 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, DW'($urandom), 1'b1, 1'b1, 1'b0);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++; if (out_therm !== '0) begin tests_failed++; $display("FAIL reset_out_therm got=%b exp=0", out_therm); end
        tests_run++; if (out_sat !== '0) begin tests_failed++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
        tests_run++; if (sat_count !== '0) begin tests_failed++; $display("FAIL reset_sat_count got=%0d exp=0", sat_count); end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk); cyc++;
    endtask

    task automatic test_unsigned_sweep();
        logic [DW-1:0] d;
        int            nx = 0;
        for (int i = 0; i < 13; i++) begin
            if (i == 0) d = {4'd5, 4'd0};
            else if (i < 9) d = {4'(8-i), 4'(i-1)};
            else d = '0;
            step(1'b0, i < 9, d, 1'b0, 1'b1, 1'b0);
            if (xfer) begin
                tests_run++;
                if (!have_exp || obs_therm !== cur_exp.therm || obs_sat !== cur_exp.sat || xfer_cyc - cur_exp.cyc != 2) begin
                    tests_failed++;
                    $display("FAIL sweep_beat%0d got=%b/%b exp=%b/%b latency=%0d exp_latency=2", nx, obs_therm, obs_sat, cur_exp.therm, cur_exp.sat, xfer_cyc - cur_exp.cyc);
                end
                if (nx == 0) begin
                    tests_run++;
                    if (obs_therm !== {7'b0011111, 7'b0000000} || obs_sat !== 2'b00) begin
                        tests_failed++;
                        $display("FAIL sweep_first got=%b/%b exp=00111110000000/00", obs_therm, obs_sat);
                    end
                end
                nx++;
            end
        end
        tests_run++; if (nx != 9 || q.size() != 0) begin tests_failed++; $display("FAIL sweep_count got=%0d left=%0d exp=9 left=0", nx, q.size()); end
    endtask

    task automatic test_unsigned_overflow();
        bit seen = 0;
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, {4'd3, 4'b1000}, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (xfer) begin
                seen = 1;
                tests_run++;
                if (obs_therm !== {7'b0000111, 7'b1111111} || obs_sat !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL overflow_beat got=%b/%b exp=00001111111111/01", obs_therm, obs_sat);
                end
            end
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL overflow_delivered got=0 exp=1"); end
        tests_run++; if (sat_count !== 2'd1) begin tests_failed++; $display("FAIL overflow_sat_count got=%0d exp=1", sat_count); end
    endtask

    task automatic test_signed();
        int nx = 0;
        step(1'b0, 1'b1, {4'b0110, 4'b1101}, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, {4'b0110, 4'b1101}, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
            if (xfer) begin
                tests_run++;
                if (!have_exp || obs_therm !== cur_exp.therm || obs_sat !== cur_exp.sat) begin
                    tests_failed++;
                    $display("FAIL signed_model%0d got=%b/%b exp=%b/%b", nx, obs_therm, obs_sat, cur_exp.therm, cur_exp.sat);
                end
                tests_run++;
                if (nx == 0 && (obs_therm !== {7'b0111111, 7'b0000000} || obs_sat !== 2'b01)) begin
                    tests_failed++;
                    $display("FAIL signed_const got=%b/%b exp=01111110000000/01", obs_therm, obs_sat);
                end else if (nx == 1 && (obs_therm !== {7'b0111111, 7'b1111111} || obs_sat !== 2'b01)) begin
                    tests_failed++;
                    $display("FAIL mode_switch_const got=%b/%b exp=01111111111111/01", obs_therm, obs_sat);
                end
                nx++;
            end
        end
        tests_run++; if (nx != 2) begin tests_failed++; $display("FAIL signed_count got=%0d exp=2", nx); end
    endtask

    task automatic test_backpressure();
        int            sent = 0, got = 0;
        logic [OW-1:0] held_t;
        logic [NL-1:0] held_s;
        logic [DW-1:0] d;
        logic          m, stall;
        d = DW'($urandom); m = 1'($urandom);
        for (int s = 0; s < 12; s++) begin
            stall = (s >= 3 && s < 6);
            step(1'b0, sent < 4, d, m, !stall, 1'b0);
            if (acc) begin sent++; d = DW'($urandom); m = 1'($urandom); end
            if (xfer) begin
                got++;
                tests_run++;
                if (!have_exp || obs_therm !== cur_exp.therm || obs_sat !== cur_exp.sat) begin
                    tests_failed++;
                    $display("FAIL bp_beat%0d got=%b/%b exp=%b/%b", got, obs_therm, obs_sat, cur_exp.therm, cur_exp.sat);
                end
            end
            if (s == 3) begin held_t = obs_therm; held_s = obs_sat; end
            if (stall) begin
                tests_run++;
                if (obs_ready !== 1'b0 || obs_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL bp_stall%0d in_ready=%b out_valid=%b exp in_ready=0 out_valid=1", s, obs_ready, obs_valid);
                end
            end
            if (s >= 4 && s <= 6) begin
                tests_run++;
                if (obs_therm !== held_t || obs_sat !== held_s) begin
                    tests_failed++;
                    $display("FAIL bp_hold%0d got=%b/%b exp=%b/%b", s, obs_therm, obs_sat, held_t, held_s);
                end
            end
        end
        tests_run++; if (got != 4 || q.size() != 0) begin tests_failed++; $display("FAIL bp_delivered got=%0d left=%0d exp=4 left=0", got, q.size()); end
    endtask

    task automatic test_reset_midflight();
        bit seen = 0;
        step(1'b0, 1'b1, {4'd2, 4'd9}, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        tests_run++; if (sat_count !== CW'(sat_model) || sat_model == 0) begin tests_failed++; $display("FAIL pre_reset_count got=%0d exp=%0d", sat_count, sat_model); end
        step(1'b0, 1'b1, {4'd2, 4'd9}, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, {4'd1, 4'd3}, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
        tests_run++; if (sat_count !== '0) begin tests_failed++; $display("FAIL midreset_sat_count got=%0d exp=0", sat_count); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (obs_valid !== 1'b0) seen = 1;
        end
        tests_run++; if (seen) begin tests_failed++; $display("FAIL midreset_stale got=1 exp=0"); end
    endtask

    task automatic test_counter();
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, i < 5, {4'd1, 4'b1111}, 1'b0, 1'b1, 1'b0);
            tests_run++; if (sat_count !== CW'(sat_model)) begin tests_failed++; $display("FAIL cnt_step%0d got=%0d exp=%0d", i, sat_count, sat_model); end
        end
        tests_run++; if (sat_count !== 2'd3) begin tests_failed++; $display("FAIL cnt_saturate got=%0d exp=3", sat_count); end
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        tests_run++; if (sat_count !== 2'd0) begin tests_failed++; $display("FAIL cnt_clear got=%0d exp=0", sat_count); end
        step(1'b0, 1'b1, {4'b1000, 4'd0}, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        tests_run++; if (sat_count !== 2'd1) begin tests_failed++; $display("FAIL cnt_one got=%0d exp=1", sat_count); end
        step(1'b0, 1'b1, {4'b1000, 4'd0}, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        tests_run++; if (!xfer || sat_count !== 2'd0) begin tests_failed++; $display("FAIL cnt_clr_wins xfer=%b got=%0d exp xfer=1 count=0", xfer, sat_count); end
    endtask

    task automatic test_random();
        logic          prev_stall = 1'b0;
        logic [OW-1:0] prev_t;
        logic [NL-1:0] prev_s;
        logic          ordy;
        for (int i = 0; i < 300; i++) begin
            ordy = ($urandom_range(3) != 0);
            step(1'b0, $urandom_range(3) != 0, DW'($urandom), 1'($urandom), ordy, $urandom_range(31) == 0);
            if (xfer) begin
                tests_run++;
                if (!have_exp || obs_therm !== cur_exp.therm || obs_sat !== cur_exp.sat) begin
                    tests_failed++;
                    $display("FAIL rand_beat cyc=%0d got=%b/%b exp=%b/%b have=%0d", cyc, obs_therm, obs_sat, cur_exp.therm, cur_exp.sat, have_exp);
                end
            end
            if (prev_stall) begin
                tests_run++;
                if (obs_valid !== 1'b1 || obs_therm !== prev_t || obs_sat !== prev_s) begin
                    tests_failed++;
                    $display("FAIL rand_hold cyc=%0d got=%b/%b/%b exp=1/%b/%b", cyc, obs_valid, obs_therm, obs_sat, prev_t, prev_s);
                end
            end
            prev_stall = (obs_valid === 1'b1) && !ordy;
            prev_t = obs_therm; prev_s = obs_sat;
            tests_run++;
            if (sat_count !== CW'(sat_model)) begin
                tests_failed++;
                $display("FAIL rand_sat_count cyc=%0d got=%0d exp=%0d", cyc, sat_count, sat_model);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (xfer) begin
                tests_run++;
                if (!have_exp || obs_therm !== cur_exp.therm || obs_sat !== cur_exp.sat) begin
                    tests_failed++;
                    $display("FAIL rand_drain got=%b/%b exp=%b/%b", obs_therm, obs_sat, cur_exp.therm, cur_exp.sat);
                end
            end
        end
        tests_run++; if (q.size() != 0) begin tests_failed++; $display("FAIL rand_lost got=%0d exp=0", q.size()); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; cyc = 0; sat_model = 0;
        rst = 1'b1; mode = 1'b0; sat_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        test_reset();
        test_unsigned_sweep();
        test_unsigned_overflow();
        test_signed();
        test_backpressure();
        test_reset_midflight();
        test_counter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
